// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin bus arbiter with optional hold-limit
// preemption and tracking of a single outstanding split transaction.
// All outputs are registered; a request seen in one cycle is granted in the next.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_WIDTH   = $clog2(NUM_MASTERS),
    parameter int MAX_HOLD    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [SEL_WIDTH-1:0]   msel,
    input  logic                   sready,
    input  logic                   ssplit,
    input  logic                   split_sready,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic                   split_grant
);

    // Hold counter saturates, so it only needs to reach MAX_HOLD-1.
    localparam int HW = $clog2(MAX_HOLD + 1) + 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_bgrant, w_bgrant_nxt;
    logic [SEL_WIDTH-1:0]   r_msel, w_msel_nxt;
    logic [NUM_MASTERS-1:0] r_msplit, w_msplit_nxt;
    logic                   r_split_grant, w_split_grant_nxt;
    logic [SEL_WIDTH-1:0]   r_ptr, w_ptr_nxt;
    logic [HW-1:0]          r_hold, w_hold_nxt;
    logic                   r_split_pending, w_split_pending_nxt;
    logic [SEL_WIDTH-1:0]   r_split_owner, w_split_owner_nxt;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_others;
    logic                   w_rr_found;
    logic [SEL_WIDTH-1:0]   w_rr_idx;
    logic                   w_preempt;
    logic                   w_release;

    assign bgrant      = r_bgrant;
    assign msel        = r_msel;
    assign msplit      = r_msplit;
    assign split_grant = r_split_grant;

    // Eligible requesters (split-waiting masters are masked) and the round-robin winner after r_ptr.
    always_comb begin
        w_eligible = breq & ~r_msplit;
        w_others   = w_eligible;
        w_others[r_msel] = 1'b0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!w_rr_found && w_eligible[(int'(r_ptr) + i) % NUM_MASTERS]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SEL_WIDTH'((int'(r_ptr) + i) % NUM_MASTERS);
            end
        end
    end

    // Release conditions for the current owner: normal end of tenure or hold-limit preemption.
    always_comb begin
        w_preempt = (MAX_HOLD > 0) && !r_split_grant && (r_hold >= HOLD_LIM)
                    && sready && (|w_others);
        w_release = (!breq[r_msel] && sready) || w_preempt;
    end

    // Next-state and next-output logic; defaults hold the current values.
    always_comb begin
        w_state_nxt         = r_state;
        w_bgrant_nxt        = r_bgrant;
        w_msel_nxt          = r_msel;
        w_msplit_nxt        = r_msplit;
        w_split_grant_nxt   = r_split_grant;
        w_ptr_nxt           = r_ptr;
        w_hold_nxt          = r_hold;
        w_split_pending_nxt = r_split_pending;
        w_split_owner_nxt   = r_split_owner;
        case (r_state)
            IDLE: begin
                if (r_split_pending && split_sready) begin
                    // Resuming the split transaction beats any new request.
                    w_bgrant_nxt                  = '0;
                    w_bgrant_nxt[r_split_owner]   = 1'b1;
                    w_msel_nxt                    = r_split_owner;
                    w_msplit_nxt[r_split_owner]   = 1'b0;
                    w_split_pending_nxt           = 1'b0;
                    w_split_grant_nxt             = 1'b1;
                    w_hold_nxt                    = '0;
                    w_state_nxt                   = BUSY;
                end else if (w_rr_found) begin
                    w_bgrant_nxt           = '0;
                    w_bgrant_nxt[w_rr_idx] = 1'b1;
                    w_msel_nxt             = w_rr_idx;
                    w_split_grant_nxt      = 1'b0;
                    w_hold_nxt             = '0;
                    w_state_nxt            = BUSY;
                end else begin
                    w_bgrant_nxt = '0;
                end
            end
            BUSY: begin
                if (ssplit && !r_split_pending && !r_split_grant) begin
                    // Split wins over a simultaneous release.
                    w_msplit_nxt[r_msel] = 1'b1;
                    w_split_pending_nxt  = 1'b1;
                    w_split_owner_nxt    = r_msel;
                    w_bgrant_nxt         = '0;
                    w_split_grant_nxt    = 1'b0;
                    w_ptr_nxt            = r_msel;
                    w_state_nxt          = IDLE;
                end else if (w_release) begin
                    w_bgrant_nxt      = '0;
                    w_split_grant_nxt = 1'b0;
                    w_ptr_nxt         = r_msel;
                    w_state_nxt       = IDLE;
                end else if (r_hold != {HW{1'b1}}) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset forgets any pending split.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_bgrant        <= '0;
            r_msel          <= '0;
            r_msplit        <= '0;
            r_split_grant   <= 1'b0;
            r_ptr           <= SEL_WIDTH'(NUM_MASTERS - 1);
            r_hold          <= '0;
            r_split_pending <= 1'b0;
            r_split_owner   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_bgrant        <= w_bgrant_nxt;
            r_msel          <= w_msel_nxt;
            r_msplit        <= w_msplit_nxt;
            r_split_grant   <= w_split_grant_nxt;
            r_ptr           <= w_ptr_nxt;
            r_hold          <= w_hold_nxt;
            r_split_pending <= w_split_pending_nxt;
            r_split_owner   <= w_split_owner_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr (4 masters, hold limit 4): directed scenarios plus
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_bus_arbiter_rr;

    localparam int NM   = 4;
    localparam int MAXH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NM-1:0] breq = '0;
    logic [NM-1:0] bgrant;
    logic [1:0]    msel;
    logic          sready = 1'b0;
    logic          ssplit = 1'b0;
    logic          split_sready = 1'b0;
    logic [NM-1:0] msplit;
    logic          split_grant;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: owner index (-1 = bus free), fairness pointer, split bookkeeping.
    int          m_owner  = -1;
    int          m_ptr    = NM - 1;
    int          m_hold   = 0;
    int          m_msel   = 0;
    int          m_sowner = 0;
    bit          m_pend   = 0;
    bit          m_sg     = 0;
    logic [NM-1:0] m_msplit = '0;

    bus_arbiter_rr #(.NUM_MASTERS(NM), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .breq(breq), .bgrant(bgrant), .msel(msel),
        .sready(sready), .ssplit(ssplit), .split_sready(split_sready),
        .msplit(msplit), .split_grant(split_grant)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [NM-1:0] elig;
        logic [NM-1:0] others;
        if (rst) begin
            m_owner = -1; m_ptr = NM - 1; m_hold = 0; m_msel = 0;
            m_sowner = 0; m_pend = 0; m_sg = 0; m_msplit = '0;
            return;
        end
        elig = breq & ~m_msplit;
        if (m_owner < 0) begin
            if (m_pend && split_sready) begin
                m_owner = m_sowner; m_msel = m_sowner; m_msplit[m_sowner] = 1'b0;
                m_pend = 0; m_sg = 1; m_hold = 0;
            end else begin
                for (int k = 1; k <= NM; k++) begin
                    if (m_owner < 0 && elig[(m_ptr + k) % NM]) begin
                        m_owner = (m_ptr + k) % NM; m_msel = m_owner; m_sg = 0; m_hold = 0;
                    end
                end
            end
        end else begin
            others = elig;
            others[m_owner] = 1'b0;
            if (ssplit && !m_pend && !m_sg) begin
                m_msplit[m_owner] = 1'b1; m_pend = 1; m_sowner = m_owner;
                m_ptr = m_owner; m_owner = -1; m_sg = 0;
            end else if ((!breq[m_owner] && sready) ||
                         (!m_sg && m_hold + 1 >= MAXH && sready && others != 0)) begin
                m_ptr = m_owner; m_owner = -1; m_sg = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    // Advance one clock; the model sees exactly the inputs the DUT samples.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; breq = '0; sready = 1'b0; ssplit = 1'b0; split_sready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        breq = 4'b1111; sready = 1'b1;
        tick(); tick();
        do_reset();
        checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL reset_bgrant got=%b exp=0000", bgrant); end
        checks++; if (msel !== 2'd0) begin failures++; $display("FAIL reset_msel got=%0d exp=0", msel); end
        checks++; if (msplit !== 4'b0000) begin failures++; $display("FAIL reset_msplit got=%b exp=0000", msplit); end
        checks++; if (split_grant !== 1'b0) begin failures++; $display("FAIL reset_split_grant got=%b exp=0", split_grant); end
    endtask

    task automatic test_rr_order();
        logic [NM-1:0] exp;
        do_reset();
        breq = 4'b1111; sready = 1'b1;
        checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL rr_latency got=%b exp=0000", bgrant); end
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = '0; exp[k % NM] = 1'b1;
            checks++; if (bgrant !== exp || msel !== 2'(k % NM)) begin
                failures++; $display("FAIL rr_grant%0d bgrant=%b msel=%0d exp=%b/%0d", k, bgrant, msel, exp, k % NM);
            end
            tick(); tick();
            checks++; if (bgrant !== exp) begin failures++; $display("FAIL rr_hold%0d got=%b exp=%b", k, bgrant, exp); end
            breq[k % NM] = 1'b0;
            tick();
            checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL rr_release%0d got=%b exp=0000", k, bgrant); end
            breq[k % NM] = 1'b1;
            tick();
        end
    endtask

    task automatic test_wait_sready();
        do_reset();
        breq = 4'b0100; sready = 1'b1;
        tick();
        checks++; if (bgrant !== 4'b0100 || msel !== 2'd2) begin failures++; $display("FAIL single_grant bgrant=%b msel=%0d exp=0100/2", bgrant, msel); end
        breq = 4'b0000; sready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bgrant !== 4'b0100) begin failures++; $display("FAIL wait_sready%0d got=%b exp=0100", i, bgrant); end
        end
        sready = 1'b1;
        tick();
        checks++; if (bgrant !== 4'b0000 || msel !== 2'd2) begin failures++; $display("FAIL sready_release bgrant=%b msel=%0d exp=0000/2", bgrant, msel); end
    endtask

    task automatic test_split_resume();
        do_reset();
        breq = 4'b0010; sready = 1'b1;
        tick();
        checks++; if (bgrant !== 4'b0010) begin failures++; $display("FAIL split_pre got=%b exp=0010", bgrant); end
        ssplit = 1'b1;
        tick();
        ssplit = 1'b0;
        checks++; if (msplit !== 4'b0010 || bgrant !== 4'b0000) begin failures++; $display("FAIL split_taken msplit=%b bgrant=%b exp=0010/0000", msplit, bgrant); end
        tick();
        checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL split_owner_ignored got=%b exp=0000", bgrant); end
        breq = 4'b1010;
        tick();
        checks++; if (bgrant !== 4'b1000 || msplit !== 4'b0010) begin failures++; $display("FAIL split_other_grant bgrant=%b msplit=%b exp=1000/0010", bgrant, msplit); end
        breq = 4'b0111; split_sready = 1'b1;
        tick();
        checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL split_m3_release got=%b exp=0000", bgrant); end
        tick();
        split_sready = 1'b0;
        checks++; if (bgrant !== 4'b0010 || split_grant !== 1'b1 || msplit !== 4'b0000 || msel !== 2'd1) begin
            failures++; $display("FAIL resume bgrant=%b sg=%b msplit=%b msel=%0d exp=0010/1/0000/1", bgrant, split_grant, msplit, msel);
        end
        ssplit = 1'b1;
        tick(); tick();
        ssplit = 1'b0;
        checks++; if (bgrant !== 4'b0010 || msplit !== 4'b0000 || split_grant !== 1'b1) begin
            failures++; $display("FAIL resume_ssplit_ignored bgrant=%b msplit=%b sg=%b exp=0010/0000/1", bgrant, msplit, split_grant);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        breq = 4'b0001; sready = 1'b1;
        tick();
        checks++; if (bgrant !== 4'b0001) begin failures++; $display("FAIL preempt_first got=%b exp=0001", bgrant); end
        breq = 4'b0101;
        tick(); tick(); tick();
        checks++; if (bgrant !== 4'b0001) begin failures++; $display("FAIL preempt_cycle4 got=%b exp=0001", bgrant); end
        tick();
        checks++; if (bgrant !== 4'b0000) begin failures++; $display("FAIL preempt_release got=%b exp=0000", bgrant); end
        tick();
        checks++; if (bgrant !== 4'b0100 || msel !== 2'd2) begin failures++; $display("FAIL preempt_next bgrant=%b msel=%0d exp=0100/2", bgrant, msel); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        breq = 4'b0010; sready = 1'b1;
        tick();
        ssplit = 1'b1;
        tick();
        ssplit = 1'b0; breq = 4'b1010;
        tick();
        checks++; if (bgrant !== 4'b1000 || msplit !== 4'b0010) begin failures++; $display("FAIL rstmid_pre bgrant=%b msplit=%b exp=1000/0010", bgrant, msplit); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bgrant !== 4'b0000 || msplit !== 4'b0000 || msel !== 2'd0 || split_grant !== 1'b0) begin
            failures++; $display("FAIL rstmid_clear bgrant=%b msplit=%b msel=%0d sg=%b exp=0000/0000/0/0", bgrant, msplit, msel, split_grant);
        end
        tick();
        checks++; if (bgrant !== 4'b0010) begin failures++; $display("FAIL rstmid_first got=%b exp=0010", bgrant); end
    endtask

    task automatic test_random();
        logic [NM-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NM; b++)
                if ($urandom_range(0, 3) == 0) breq[b] = ~breq[b];
            sready       = ($urandom_range(0, 3) != 0);
            ssplit       = ($urandom_range(0, 7) == 0);
            split_sready = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
            exp_g = '0;
            if (m_owner >= 0) exp_g[m_owner] = 1'b1;
            checks++; if (bgrant !== exp_g || msel !== 2'(m_msel) || msplit !== m_msplit || split_grant !== m_sg) begin
                failures++;
                $display("FAIL random c=%0d bgrant=%b msel=%0d msplit=%b sg=%b exp=%b/%0d/%b/%b",
                         c, bgrant, msel, msplit, split_grant, exp_g, m_msel, m_msplit, m_sg);
            end
            checks++; if ($countones(bgrant) > 1) begin failures++; $display("FAIL onehot c=%0d got=%b exp=onehot_or_zero", c, bgrant); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_wait_sready();
        test_split_resume();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
